// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder/subtractor).
// State encodings are common so bench state monitors work on either block.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ADDING   = 2'b01,
      ST_COMPLETE = 2'b10
   } state_e;

endpackage : serial_arith_pkg

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder: s = a ^ b ^ ci, co = majority(a, b, ci).
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first: {cout, sum} = a + b + cin.
// One bit per clock through a single full adder. The result registers
// update only on the completion edge, so partial sums are never visible.
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // state and bit_counter keep these exact names for hierarchical probes
   state_e             state, state_d;
   logic [CNT_W-1:0]   bit_counter, bit_counter_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic               fa_s;
   logic               fa_co;

   full_adder_bit u_full_adder_bit (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Next-state and datapath: accept, shift one bit per clock, publish on last bit
   always_comb begin
      // NOTE: every _d defaults to its current value first, so no branch can leave one unassigned and infer a latch.
      state_d       = state;
      bit_counter_d = bit_counter;
      a_d           = a_q;
      b_d           = b_q;
      acc_d         = acc_q;
      sum_d         = sum_q;
      carry_d       = carry_q;
      cout_d        = cout_q;
      done_d        = done_q;
      busy_d        = busy_q;

      case (state)
         ST_IDLE, ST_COMPLETE: begin
            // sum/cout stay as they are until the new operation completes
            if (start) begin
               a_d           = a;
               b_d           = b;
               carry_d       = cin;
               bit_counter_d = '0;
               done_d        = 1'b0;
               busy_d        = 1'b1;
               state_d       = ST_ADDING;
            end
         end

         ST_ADDING: begin
            // start is deliberately ignored here: no restart, no queueing
            acc_d         = {fa_s, acc_q[WIDTH-1:1]};
            a_d           = a_q >> 1;
            b_d           = b_q >> 1;
            carry_d       = fa_co;
            bit_counter_d = bit_counter + CNT_W'(1);
            if (bit_counter == LAST_BIT) begin
               sum_d   = {fa_s, acc_q[WIDTH-1:1]};
               cout_d  = fa_co;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_COMPLETE;
            end
         end

         default: begin
            // unused encoding 2'b11 recovers to IDLE
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset that aborts any operation
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state       <= ST_IDLE;
         bit_counter <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_d;
         bit_counter <= bit_counter_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a transaction-level model ({cout,sum} = a+b+cin,
// result appears WIDTH clocks after acceptance) compared every cycle, plus
// directed vectors with hand-computed literal results and latencies.
module tb_serial_adder;
   import serial_arith_pkg::*;

   localparam int WIDTH = 32;

   logic             clk   = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             cin   = 1'b0;
   logic [WIDTH-1:0] a     = '0;
   logic [WIDTH-1:0] b     = '0;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             done;
   logic             busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit cmp_en   = 1'b0;

   always #2 clk = ~clk;

   always @(posedge clk) cyc++;

   serial_adder #(
      .WIDTH (WIDTH),
      .CNT_W (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sum   (sum),
      .cout  (cout),
      .done  (done),
      .busy  (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one pending result, released after WIDTH clocks
   int               m_left    = 0;
   logic             m_done    = 1'b0;
   logic [WIDTH-1:0] m_sum     = '0;
   logic             m_cout    = 1'b0;
   logic [WIDTH:0]   m_pending = '0;

   always @(posedge clk) begin
      if (!reset) begin
         m_left = 0;
         m_done = 1'b0;
         m_sum  = '0;
         m_cout = 1'b0;
      end else if (m_left == 0) begin
         if (start) begin
            m_pending = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            m_left    = WIDTH;
            m_done    = 1'b0;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            {m_cout, m_sum} = m_pending;
            m_done = 1'b1;
         end
      end
   end

   // Compare process: DUT outputs against the model on every falling edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_done", done, m_done);
         check("model_busy", busy, (m_left != 0));
         check("model_sum",  sum,  m_sum);
         check("model_cout", cout, m_cout);
         check("busy_done_exclusive", busy & done, 1'b0);
      end
   end

   // Waits (bounded) for done, returns clocks elapsed since the accept edge
   task automatic wait_done(input int t0, output int lat);
      int guard;
      guard = 0;
      while (!done && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      lat = cyc - t0;
   endtask

   task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic [WIDTH-1:0] es, input logic ec,
                         input string nm);
      int t0;
      int lat;
      @(negedge clk);
      a = ia; b = ib; cin = ic; start = 1'b1;
      @(negedge clk);
      t0 = cyc;
      start = 1'b0;
      a = $urandom; b = $urandom; cin = 1'b1;
      wait_done(t0, lat);
      check({nm, "_latency"}, lat, WIDTH);
      check({nm, "_sum"}, sum, es);
      check({nm, "_cout"}, cout, ec);
   endtask

   initial begin
      int t0;
      int lat;
      int guard;

      // reset state
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_sum",   sum,  '0);
      check("rst_cout",  cout, 1'b0);
      check("rst_done",  done, 1'b0);
      check("rst_busy",  busy, 1'b0);
      check("rst_state", dut.state, ST_IDLE);
      reset  = 1'b1;
      cmp_en = 1'b1;

      // basic and boundary vectors
      run_op(32'd30,        32'd20,        1'b0, 32'd50,        1'b0, "t1_30p20");
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "t2_wrap");
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, "t3_hex");
      run_op(32'd99,        32'd100,       1'b1, 32'd200,       1'b0, "t3_cin");
      run_op(32'hFFFF_FFF1, 32'h0000_000F, 1'b0, 32'h0000_0000, 1'b1, "t4_roundtrip");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, "t4_allones");

      // start pulsed mid-operation with new operands is ignored
      @(negedge clk);
      a = 32'd30; b = 32'd20; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      t0 = cyc;
      start = 1'b0;
      repeat (5) @(negedge clk);
      a = 32'd1; b = 32'd1; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(t0, lat);
      check("t5_ignore_latency", lat, WIDTH);
      check("t5_ignore_sum", sum, 32'd50);
      check("t5_ignore_cout", cout, 1'b0);

      // start held high: two back-to-back operations
      @(negedge clk);
      a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      t0 = cyc;
      wait_done(t0, lat);
      check("t5_b2b1_latency", lat, WIDTH);
      check("t5_b2b1_sum", sum, 32'h0000_0001);
      check("t5_b2b1_cout", cout, 1'b1);
      a = 32'd1000; b = 32'd234; cin = 1'b0;
      @(negedge clk);
      t0 = cyc;
      check("t5_b2b2_done_low", done, 1'b0);
      wait_done(t0, lat);
      start = 1'b0;
      check("t5_b2b2_latency", lat, WIDTH);
      check("t5_b2b2_sum", sum, 32'd1234);
      check("t5_b2b2_cout", cout, 1'b0);

      // reset mid-operation aborts and clears the result
      @(negedge clk);
      a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (dut.bit_counter != 6'd10 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("t6_reach_bit10", dut.bit_counter, 6'd10);
      reset = 1'b0;
      @(negedge clk);
      check("t6_state", dut.state, ST_IDLE);
      check("t6_sum",   sum,  '0);
      check("t6_cout",  cout, 1'b0);
      check("t6_done",  done, 1'b0);
      check("t6_busy",  busy, 1'b0);
      reset = 1'b1;
      run_op(32'd7, 32'd8, 1'b0, 32'd15, 1'b0, "t6_after");

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_adder
